// File: rtl/aether_cmd_sequencer.sv
// Command sequencer: queues {wait, cmd} entries and feeds the engine one command per cycle,
// optionally holding for an interrupt and then issuing a status-clear acknowledgement.

module aether_cmd_sequencer #(
   parameter int unsigned InstrWidth    = 4,
   parameter int unsigned Param1Width   = 4,
   parameter int unsigned Param2Width   = 16,
   parameter int unsigned FifoDepth     = 16,
   parameter int unsigned TimeoutCycles = 4096,
   // {RDR, REG_STATS, 16'h0000}
   parameter logic [InstrWidth+Param1Width+Param2Width-1:0] AckCmd = {4'hA, 4'h3, 16'h0000},
   localparam int unsigned CmdW   = InstrWidth + Param1Width + Param2Width,
   localparam int unsigned LevelW = $clog2(FifoDepth + 1)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   wr_valid_i,
   input  logic [CmdW-1:0]        wr_cmd_i,
   input  logic                   wr_wait_i,
   output logic                   wr_ready_o,
   input  logic                   flush_i,
   input  logic                   interrupt_i,
   output logic [InstrWidth-1:0]  instruction_o,
   output logic [Param1Width-1:0] param_1_o,
   output logic [Param2Width-1:0] param_2_o,
   output logic                   issue_o,
   output logic                   busy_o,
   output logic [LevelW-1:0]      level_o,
   output logic                   timeout_o
);

   localparam int unsigned PtrW = $clog2(FifoDepth);
   localparam int unsigned EntW = CmdW + 1;
   localparam int unsigned TmoW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   localparam logic [TmoW-1:0]   TmoLast   = TmoW'(TimeoutCycles - 1);
   localparam logic [LevelW-1:0] LevelFull = LevelW'(FifoDepth);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StIssue = 2'd1;
   localparam logic [1:0] StWait  = 2'd2;
   localparam logic [1:0] StAck   = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [LevelW-1:0]     level_q, level_d;
   logic [CmdW-1:0]       out_cmd_q, out_cmd_d;
   logic                  issue_q, issue_d;
   logic                  timeout_q, timeout_d;
   logic [TmoW-1:0]       tmo_cnt_q, tmo_cnt_d;
   logic                  irq_prev_q;

   logic [FifoDepth*EntW-1:0] slots_flat;
   logic [EntW-1:0]           head_entry;
   logic                      full, empty, push, pop, irq_rise;

   assign full       = (level_q == LevelFull);
   assign empty      = (level_q == '0);
   assign wr_ready_o = !full && !flush_i;
   assign push       = wr_valid_i && wr_ready_o;
   assign irq_rise   = interrupt_i && !irq_prev_q;

   // Each slot keeps its {wait, cmd} entry; writes target the slot under the write pointer.
   for (genvar gi = 0; gi < FifoDepth; gi++) begin : g_slot
      logic [EntW-1:0] slot_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            slot_q <= '0;
         end else if (push && (wr_ptr_q == PtrW'(gi))) begin
            slot_q <= {wr_wait_i, wr_cmd_i};
         end
      end

      assign slots_flat[gi*EntW +: EntW] = slot_q;
   end

   always_comb begin
      head_entry = '0;
      for (int i = 0; i < FifoDepth; i++) begin
         if (rd_ptr_q == PtrW'(i)) begin
            head_entry = slots_flat[i*EntW +: EntW];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      out_cmd_d = '0;
      issue_d   = 1'b0;
      timeout_d = timeout_q;
      tmo_cnt_d = tmo_cnt_q;
      pop       = 1'b0;

      if (flush_i) begin
         state_d   = StIdle;
         timeout_d = 1'b0;
         tmo_cnt_d = '0;
      end else if (state_q == StWait) begin
         // The cycle the wait command itself is on the outputs cannot release it.
         if (!issue_q && irq_rise) begin
            state_d   = StAck;
            out_cmd_d = AckCmd;
            issue_d   = 1'b1;
         end else if (tmo_cnt_q == TmoLast) begin
            state_d   = StIdle;
            timeout_d = 1'b1;
         end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
         end
      end else if (!empty) begin
         pop       = 1'b1;
         out_cmd_d = head_entry[CmdW-1:0];
         issue_d   = 1'b1;
         if (head_entry[CmdW]) begin
            state_d   = StWait;
            tmo_cnt_d = '0;
         end else begin
            state_d = StIssue;
         end
      end else begin
         state_d = StIdle;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            level_d = level_q + 1'b1;
         end else if (pop && !push) begin
            level_d = level_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         out_cmd_q  <= '0;
         issue_q    <= 1'b0;
         timeout_q  <= 1'b0;
         tmo_cnt_q  <= '0;
         irq_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         out_cmd_q  <= out_cmd_d;
         issue_q    <= issue_d;
         timeout_q  <= timeout_d;
         tmo_cnt_q  <= tmo_cnt_d;
         irq_prev_q <= interrupt_i;
      end
   end

   assign instruction_o = out_cmd_q[CmdW-1 -: InstrWidth];
   assign param_1_o     = out_cmd_q[Param2Width +: Param1Width];
   assign param_2_o     = out_cmd_q[Param2Width-1:0];
   assign issue_o       = issue_q;
   assign busy_o        = !empty || (state_q != StIdle);
   assign level_o       = level_q;
   assign timeout_o     = timeout_q;

endmodule
